fifo_umbrales: RTL and testbench
================================

# fifo_umbrales

Synchronous FIFO with programmable almost-full/almost-empty thresholds. It is the buffer on either side of the empty/pause pop controller: as a VC FIFO it feeds `vcX_empty` into the controller and accepts `pop_vcX`; as a destination FIFO (D0/D1) it drives `pause_dX` back to the controller through `almost_full`. Read data is registered, so it is valid one cycle after `pop`, matching the controller's registered `valid_vcX`.

## Interface
Parameters
- `DATA_WIDTH`, default 6: word width.
- `ADDR_WIDTH`, default 2: pointer width; depth `DEPTH = 2**ADDR_WIDTH`.

Ports
- `clk` — in, 1: single clock, rising edge.
- `reset_L` — in, 1: reset, asynchronous, active-low.
- `push` — in, 1: write request.
- `data_in` — in, DATA_WIDTH: write data.
- `pop` — in, 1: read request.
- `umbral_alto` — in, ADDR_WIDTH+1: almost-full threshold, in words.
- `umbral_bajo` — in, ADDR_WIDTH+1: almost-empty threshold, in words.
- `data_out` — out, DATA_WIDTH: registered read data.
- `count` — out, ADDR_WIDTH+1: current occupancy, 0..DEPTH.
- `full` — out, 1: `count == DEPTH`.
- `empty` — out, 1: `count == 0`.
- `almost_full` — out, 1: `count >= umbral_alto`; used as pause.
- `almost_empty` — out, 1: `count <= umbral_bajo`.
- `error` — out, 1: sticky overflow/underflow flag.

## Operation
Storage and pointers
- DEPTH x DATA_WIDTH register array.
- `wr_ptr` and `rd_ptr` are ADDR_WIDTH bits and wrap modulo DEPTH.
- `count` is an explicit register.

Reset (`reset_L = 0`, asynchronous)
- Cleared: `wr_ptr`, `rd_ptr`, `count`, `data_out`, `error`. The memory array is not cleared.
- Resulting outputs: `empty = 1`, `full = 0`, `almost_empty = 1`, `almost_full = (umbral_alto == 0)`.
- Reset asserted mid-operation discards all contents immediately. No partial write survives.

Per clock edge, with `reset_L = 1`
- Write is accepted iff `push && (!full || pop)`: `mem[wr_ptr] <= data_in`, `wr_ptr++`.
- Read is accepted iff `pop && !empty`: `data_out <= mem[rd_ptr]`, `rd_ptr++`.
- `count` update: +1 for a write only; −1 for a read only; unchanged when both or neither are accepted.
- Push while full and no pop (overflow): the write is dropped, `error <= 1`, pointers and count are unchanged.
- Pop while empty (underflow): no read, `data_out` holds, `error <= 1`. A simultaneous push is still accepted (count 0→1).
- Push and pop while full: both are accepted, count stays DEPTH, `data_out` takes the oldest word (pre-write memory contents), no error.
- `error` stays set until reset.
- `data_out` holds its last value whenever no read is accepted.

Flags
- `full`, `empty`, `almost_full`, `almost_empty` are combinational decodes of the registered `count` and the threshold inputs. There is no combinational path from `push`/`pop` to any flag, so `empty` → controller `pop` cannot form a loop.
- Thresholds may change at any time; the flags follow in the same cycle.
- `umbral_alto > DEPTH` forces `almost_full = 0`.

## Timing
- Write-to-empty deassertion: 1 cycle. Push at edge N → `empty = 0` after edge N.
- Read latency: 1 cycle. Pop sampled at edge N → word on `data_out` after edge N, aligned with the controller's `valid_vcX`.
- Pause latency: `almost_full` rises after the edge at which `count` reaches `umbral_alto`. Upstream must tolerate DEPTH − `umbral_alto` words of skid.
- Throughput: one push and one pop per cycle, sustained.
- Pointer wrap: after index DEPTH−1 the next access is index 0, with no bubble.

## Test plan
- Reset/flags: assert `reset_L = 0` asynchronously mid-cycle with `count = 3` → outputs change before the next edge: `count = 0`, `empty = 1`, `data_out = 0`, `error = 0`.
- Fill/drain: DEPTH = 4, `umbral_alto = 3`, `umbral_bajo = 1`.
  - Push 0x11, 0x22, 0x33, 0x04 → `almost_full` rises after the 3rd push; `full = 1` after the 4th.
  - Pop 4 times → `data_out` shows 0x11, 0x22, 0x33, 0x04, each one cycle after its pop.
  - `almost_empty` rises when `count = 1`.
- Overflow/underflow:
  - Push a 5th word while full → `count` stays 4, `error = 1`, later reads show no corruption.
  - After reset, pop while empty → `error = 1`, `data_out` unchanged.
- Simultaneous push and pop:
  - While full: push 0x3F, pop → `data_out` = oldest word, `count = 4`, `error = 0`.
  - While empty: push 0x05, pop → `count = 1`, `error = 1`.
- Wrap-around: 10 cycles of streaming push+pop at `count = 2`, data 0..9 → output order 0..9 and `count` constant at 2.
- Threshold change: at `count = 2`, write `umbral_alto` from 3 to 2 → `almost_full` asserts the same cycle, with no clock edge needed.

Source files
------------

// File: rtl/fifo_umbrales.sv
// Synchronous FIFO with registered read data and programmable almost-full /
// almost-empty thresholds; flags decode only the registered occupancy.
module fifo_umbrales #(
   parameter int DATA_WIDTH = 6,
   parameter int ADDR_WIDTH = 2
) (
   input  logic                  clk,
   input  logic                  reset_L,
   input  logic                  push,
   input  logic [DATA_WIDTH-1:0] data_in,
   input  logic                  pop,
   input  logic [ADDR_WIDTH:0]   umbral_alto,
   input  logic [ADDR_WIDTH:0]   umbral_bajo,
   output logic [DATA_WIDTH-1:0] data_out,
   output logic [ADDR_WIDTH:0]   count,
   output logic                  full,
   output logic                  empty,
   output logic                  almost_full,
   output logic                  almost_empty,
   output logic                  error
);

   localparam int DEPTH = 2 ** ADDR_WIDTH;
   localparam logic [ADDR_WIDTH:0] DEPTH_C = (ADDR_WIDTH + 1)'(DEPTH);

   logic [DATA_WIDTH-1:0] mem_q [DEPTH];
   logic [ADDR_WIDTH-1:0] wrPtr_q, wrPtr_d;
   logic [ADDR_WIDTH-1:0] rdPtr_q, rdPtr_d;
   logic [ADDR_WIDTH:0]   count_q, count_d;
   logic [DATA_WIDTH-1:0] dataOut_q, dataOut_d;
   logic                  error_q, error_d;
   logic                  wrEn, rdEn;

   // A full FIFO still accepts a write when a pop frees the slot in the same cycle.
   assign wrEn = push && (!full || pop);
   assign rdEn = pop && !empty;

   always_comb begin
      wrPtr_d   = wrPtr_q;
      rdPtr_d   = rdPtr_q;
      count_d   = count_q;
      dataOut_d = dataOut_q;
      error_d   = error_q;
      if (wrEn) begin
         wrPtr_d = wrPtr_q + 1'b1;
      end
      if (rdEn) begin
         rdPtr_d   = rdPtr_q + 1'b1;
         dataOut_d = mem_q[rdPtr_q];
      end
      if (wrEn && !rdEn) begin
         count_d = count_q + 1'b1;
      end else if (rdEn && !wrEn) begin
         count_d = count_q - 1'b1;
      end
      if ((push && full && !pop) || (pop && empty)) begin
         error_d = 1'b1;
      end
   end

   always_ff @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         wrPtr_q   <= '0;
         rdPtr_q   <= '0;
         count_q   <= '0;
         dataOut_q <= '0;
         error_q   <= 1'b0;
      end else begin
         wrPtr_q   <= wrPtr_d;
         rdPtr_q   <= rdPtr_d;
         count_q   <= count_d;
         dataOut_q <= dataOut_d;
         error_q   <= error_d;
      end
   end

   // Storage is left uncleared; reset only rewinds the pointers.
   always_ff @(posedge clk) begin
      if (reset_L && wrEn) begin
         mem_q[wrPtr_q] <= data_in;
      end
   end

   assign data_out     = dataOut_q;
   assign count        = count_q;
   assign error        = error_q;
   assign full         = (count_q == DEPTH_C);
   assign empty        = (count_q == '0);
   assign almost_full  = (umbral_alto <= DEPTH_C) && (count_q >= umbral_alto);
   assign almost_empty = (count_q <= umbral_bajo);

endmodule

// File: tb/tb_fifo_umbrales.sv
// Bench for fifo_umbrales: queue-based reference model compared every cycle,
// plus directed scenarios with hand-computed literal expectations.
module tb_fifo_umbrales;

   logic       clk = 1'b0;
   logic       reset_L = 1'b0;
   logic       push = 1'b0;
   logic       pop = 1'b0;
   logic [5:0] dataIn = '0;
   logic [2:0] umbralAlto = 3'd3;
   logic [2:0] umbralBajo = 3'd1;
   logic [5:0] dataOut;
   logic [2:0] count;
   logic       full, empty, almostFull, almostEmpty, error;

   int checks = 0;
   int errors = 0;

   logic [5:0] modelQ[$];
   logic [5:0] modelData = '0;
   logic       modelErr = 1'b0;

   fifo_umbrales #(.DATA_WIDTH(6), .ADDR_WIDTH(2)) dut (
      .clk(clk), .reset_L(reset_L), .push(push), .data_in(dataIn), .pop(pop),
      .umbral_alto(umbralAlto), .umbral_bajo(umbralBajo), .data_out(dataOut),
      .count(count), .full(full), .empty(empty), .almost_full(almostFull),
      .almost_empty(almostEmpty), .error(error)
   );

   always #5 clk = ~clk;

   task automatic checkOutput(input string name, input int actual, input int expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at %0t",
                  name, actual, actual, expected, expected, $time);
      end
   endtask

   // Reference model: a queue of at most four words, updated from sampled inputs.
   always @(posedge clk or negedge reset_L) begin
      if (!reset_L) begin
         modelQ.delete();
         modelData = '0;
         modelErr  = 1'b0;
      end else begin
         automatic int  n  = modelQ.size();
         automatic bit  wr = push && (n < 4 || pop);
         automatic bit  rd = pop && n > 0;
         if ((push && n == 4 && !pop) || (pop && n == 0)) modelErr = 1'b1;
         if (rd) modelData = modelQ.pop_front();
         if (wr) modelQ.push_back(dataIn);
      end
   end

   // Every falling edge outside reset, all outputs must agree with the model.
   always @(negedge clk) begin
      if (reset_L) begin
         automatic int n = modelQ.size();
         checkOutput("model count", int'(count), n);
         checkOutput("model full", int'(full), int'(n == 4));
         checkOutput("model empty", int'(empty), int'(n == 0));
         checkOutput("model almost_full", int'(almostFull), int'(n >= int'(umbralAlto)));
         checkOutput("model almost_empty", int'(almostEmpty), int'(n <= int'(umbralBajo)));
         checkOutput("model error", int'(error), int'(modelErr));
         checkOutput("model data_out", int'(dataOut), int'(modelData));
      end
   end

   task automatic applyStimulus(input bit p, input logic [5:0] d, input bit po);
      push   = p;
      dataIn = d;
      pop    = po;
      @(posedge clk);
      #1;
      push = 1'b0;
      pop  = 1'b0;
   endtask

   task automatic pulseReset();
      #2 reset_L = 1'b0;
      #2 reset_L = 1'b1;
   endtask

   initial begin
      #12 reset_L = 1'b1;
      checkOutput("reset count", int'(count), 0);
      checkOutput("reset empty", int'(empty), 1);
      checkOutput("reset full", int'(full), 0);
      checkOutput("reset almost_empty", int'(almostEmpty), 1);
      checkOutput("reset almost_full", int'(almostFull), 0);

      // Fill with threshold 3, then overflow.
      applyStimulus(1, 6'h11, 0);
      checkOutput("push1 empty", int'(empty), 0);
      applyStimulus(1, 6'h22, 0);
      checkOutput("push2 almost_full", int'(almostFull), 0);
      applyStimulus(1, 6'h33, 0);
      checkOutput("push3 almost_full", int'(almostFull), 1);
      applyStimulus(1, 6'h04, 0);
      checkOutput("push4 full", int'(full), 1);
      applyStimulus(1, 6'h2A, 0);
      checkOutput("overflow count", int'(count), 4);
      checkOutput("overflow error", int'(error), 1);

      // Drain: data one cycle after each pop, no corruption from the dropped word.
      applyStimulus(0, 0, 1);
      checkOutput("pop1 data", int'(dataOut), 'h11);
      applyStimulus(0, 0, 1);
      checkOutput("pop2 data", int'(dataOut), 'h22);
      checkOutput("pop2 almost_empty", int'(almostEmpty), 0);
      applyStimulus(0, 0, 1);
      checkOutput("pop3 data", int'(dataOut), 'h33);
      checkOutput("pop3 almost_empty", int'(almostEmpty), 1);
      applyStimulus(0, 0, 1);
      checkOutput("pop4 data", int'(dataOut), 'h04);
      checkOutput("pop4 empty", int'(empty), 1);

      // Asynchronous reset mid-cycle with three words held.
      applyStimulus(1, 6'h07, 0);
      applyStimulus(1, 6'h08, 0);
      applyStimulus(1, 6'h09, 0);
      applyStimulus(0, 0, 1);
      checkOutput("pre-reset count", int'(count), 2);
      applyStimulus(1, 6'h0A, 0);
      checkOutput("pre-reset count3", int'(count), 3);
      #2 reset_L = 1'b0;
      #1;
      checkOutput("async reset count", int'(count), 0);
      checkOutput("async reset empty", int'(empty), 1);
      checkOutput("async reset data_out", int'(dataOut), 0);
      checkOutput("async reset error", int'(error), 0);
      #2 reset_L = 1'b1;

      // Underflow, then push+pop while empty.
      applyStimulus(0, 0, 1);
      checkOutput("underflow error", int'(error), 1);
      checkOutput("underflow data_out", int'(dataOut), 0);
      applyStimulus(1, 6'h05, 1);
      checkOutput("empty push+pop count", int'(count), 1);
      checkOutput("empty push+pop error", int'(error), 1);

      // Push+pop while full returns the oldest word without error.
      pulseReset();
      for (int i = 1; i <= 4; i++) applyStimulus(1, 6'(i), 0);
      applyStimulus(1, 6'h3F, 1);
      checkOutput("full push+pop data", int'(dataOut), 1);
      checkOutput("full push+pop count", int'(count), 4);
      checkOutput("full push+pop error", int'(error), 0);
      for (int i = 0; i < 4; i++) applyStimulus(0, 0, 1);
      checkOutput("drain after full push+pop", int'(dataOut), 'h3F);

      // Streaming across pointer wrap at constant occupancy 2.
      pulseReset();
      applyStimulus(1, 6'h30, 0);
      applyStimulus(1, 6'h31, 0);
      for (int i = 0; i < 10; i++) begin
         applyStimulus(1, 6'(i), 1);
         checkOutput("stream count", int'(count), 2);
         checkOutput("stream data", int'(dataOut), (i < 2) ? ('h30 + i) : (i - 2));
      end

      // Threshold changes take effect without a clock edge.
      #1;
      checkOutput("alto=3 almost_full", int'(almostFull), 0);
      umbralAlto = 3'd2;
      #1;
      checkOutput("alto=2 almost_full", int'(almostFull), 1);
      umbralAlto = 3'd5;
      #1;
      checkOutput("alto=5 almost_full", int'(almostFull), 0);
      umbralAlto = 3'd0;
      umbralBajo = 3'd2;
      #1;
      checkOutput("alto=0 almost_full", int'(almostFull), 1);
      checkOutput("bajo=2 almost_empty", int'(almostEmpty), 1);
      umbralAlto = 3'd3;
      umbralBajo = 3'd1;

      applyStimulus(0, 0, 1);
      checkOutput("tail data 8", int'(dataOut), 8);
      applyStimulus(0, 0, 1);
      checkOutput("tail data 9", int'(dataOut), 9);
      checkOutput("tail empty", int'(empty), 1);

      repeat (2) @(posedge clk);
      #1;
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #100000;
      $display("[TB] FAIL timeout: simulation did not complete, expected completion");
      $fatal(1, "[TB] timeout");
   end

endmodule
